cpu_sequencer: RTL and testbench

- Parametrised control core for the next-generation SCAMP CPU.
- Holds PC, IR, flag register and T-state counter. Evaluates conditional jumps and drives PC or IR immediates onto the bus.
- Presents a microcode address {opcode, T} to an external microcode ROM and consumes the decoded control bits back.
- New over the previous core: generic widths, memory stall handshake, T-state overflow detection, bus-conflict detection, configurable reset vector.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/cpu_sequencer_tstate.sv | 47 ++++
 rtl/cpu_sequencer.sv | 111 +++++++++++
 tb/tb_cpu_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the SCAMP control core: flag positions, default
// widths, the decoded control-bit layout and the jump-condition helper.
package cpu_pkg;

  // Bit positions inside the 3-bit flag vector {C,Z,LT}
  localparam int FLAG_C    = 2;
  localparam int FLAG_Z    = 1;
  localparam int FLAG_LT   = 0;
  localparam int NUM_FLAGS = 3;

  // Default datapath geometry of the core
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_T_BITS   = 3;
  localparam int DEF_OPC_BITS = 8;
  localparam int DEF_IMM_BITS = 8;

  // Decoded control word as produced by the microcode decoder, MSB first
  typedef struct packed {
    logic po;
    logic ioh;
    logic iol;
    logic ii;
    logic pp;
    logic rt;
    logic fl;
    logic jc;
    logic jz;
    logic jgt;
    logic jlt;
  } ctrl_t;

  // A jump is taken when any enabled condition matches the registered flags;
  // "greater than" means neither zero nor less-than.
  function automatic logic jump_taken(input logic [NUM_FLAGS-1:0] f,
                                      input logic jc, input logic jz,
                                      input logic jgt, input logic jlt);
    jump_taken = (jc  & f[FLAG_C]) |
                 (jz  & f[FLAG_Z]) |
                 (jlt & f[FLAG_LT]) |
                 (jgt & ~f[FLAG_Z] & ~f[FLAG_LT]);
  endfunction

endpackage

// File: rtl/cpu_sequencer_tstate.sv
// T-state counter: steps once per unstalled cycle, restarts on rt and flags
// (stickily) any wrap that happened without an explicit restart.
module tstate_counter #(
  parameter int T_BITS = 3
) (
  input  logic              clk_i,
  input  logic              rst_bar_i,
  input  logic              stall_i,
  input  logic              rt_i,
  output logic [T_BITS-1:0] t_o,
  output logic              overflow_o
);

  localparam logic [T_BITS-1:0] T_MAX = '1;

  logic [T_BITS-1:0] t_q, t_d;
  logic              ovf_q, ovf_d;

  // Next T-state: restart, wrap-with-overflow, or plain increment
  always_comb begin
    t_d   = t_q;
    ovf_d = ovf_q;
    if (rt_i) begin
      t_d = '0;
    end else if (t_q == T_MAX) begin
      t_d   = '0;
      ovf_d = 1'b1;
    end else begin
      t_d = t_q + T_BITS'(1);
    end
  end

  // Register update; reset wins over stall, stall freezes everything else
  always_ff @(posedge clk_i) begin
    if (!rst_bar_i) begin
      t_q   <= '0;
      ovf_q <= 1'b0;
    end else if (!stall_i) begin
      t_q   <= t_d;
      ovf_q <= ovf_d;
    end
  end

  assign t_o        = t_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/cpu_sequencer.sv
// SCAMP control core: PC, IR and flag registers, conditional jumps, bus
// driving of PC/immediates and the microcode address {opcode, T}.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int          DATA_W    = DEF_DATA_W,
  parameter int          T_BITS    = DEF_T_BITS,
  parameter int          OPC_BITS  = DEF_OPC_BITS,
  parameter int          IMM_BITS  = DEF_IMM_BITS,
  parameter logic [DATA_W-1:0] RESET_VEC = '0
) (
  input  logic                       clk,
  input  logic                       RST_bar,
  input  logic [DATA_W-1:0]          bus_in,
  output logic [DATA_W-1:0]          bus_out,
  output logic                       bus_oe,
  output logic [OPC_BITS+T_BITS-1:0] uaddr,
  input  logic                       po,
  input  logic                       ioh,
  input  logic                       iol,
  input  logic                       ii,
  input  logic                       pp,
  input  logic                       rt,
  input  logic                       fl,
  input  logic                       jc,
  input  logic                       jz,
  input  logic                       jgt,
  input  logic                       jlt,
  input  logic [NUM_FLAGS-1:0]       alu_flags,
  input  logic                       stall,
  output logic [DATA_W-1:0]          pc,
  output logic [DATA_W-1:0]          ir,
  output logic [T_BITS-1:0]          t,
  output logic [NUM_FLAGS-1:0]       flags,
  output logic                       t_overflow,
  output logic                       bus_conflict
);

  ctrl_t                 ctl;
  logic                  jmp;
  logic [DATA_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]     ir_q, ir_d;
  logic [NUM_FLAGS-1:0]  flags_q, flags_d;

  assign ctl = {po, ioh, iol, ii, pp, rt, fl, jc, jz, jgt, jlt};

  // Jumps look at the registered flags, so an fl in the same cycle has no effect
  assign jmp = jump_taken(flags_q, ctl.jc, ctl.jz, ctl.jgt, ctl.jlt);

  // Next-state for PC, IR and flags; a taken jump overrides the PC increment
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    if (jmp) begin
      pc_d = bus_in;
    end else if (ctl.pp) begin
      pc_d = pc_q + DATA_W'(1);
    end
    if (ctl.ii) begin
      ir_d = bus_in;
    end
    if (ctl.fl) begin
      flags_d = alu_flags;
    end
  end

  // Architectural registers; reset wins over stall, stall freezes the core
  always_ff @(posedge clk) begin
    if (!RST_bar) begin
      pc_q    <= RESET_VEC;
      ir_q    <= '0;
      flags_q <= '0;
    end else if (!stall) begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  // Bus source select with po > ioh > iol priority and conflict detection
  always_comb begin
    bus_out = '0;
    if (ctl.po) begin
      bus_out = pc_q;
    end else if (ctl.ioh) begin
      bus_out = {{OPC_BITS{1'b1}}, ir_q[IMM_BITS-1:0]};
    end else if (ctl.iol) begin
      bus_out = {{OPC_BITS{1'b0}}, ir_q[IMM_BITS-1:0]};
    end
    bus_oe       = ctl.po | ctl.ioh | ctl.iol;
    bus_conflict = (ctl.po & ctl.ioh) | (ctl.po & ctl.iol) | (ctl.ioh & ctl.iol);
  end

  tstate_counter #(
    .T_BITS (T_BITS)
  ) u_tstate (
    .clk_i      (clk),
    .rst_bar_i  (RST_bar),
    .stall_i    (stall),
    .rt_i       (ctl.rt),
    .t_o        (t),
    .overflow_o (t_overflow)
  );

  assign uaddr = {ir_q[DATA_W-1 -: OPC_BITS], t};
  assign pc    = pc_q;
  assign ir    = ir_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a behavioural model predicts every output
// each cycle, and literal expectations at key points pin the model itself.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        RST_bar;
  logic [15:0] bus_in;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic [10:0] uaddr;
  logic        po, ioh, iol, ii, pp, rt, fl, jc, jz, jgt, jlt;
  logic [2:0]  alu_flags;
  logic        stall;
  logic [15:0] pc, ir;
  logic [2:0]  t;
  logic [2:0]  flags;
  logic        t_overflow;
  logic        bus_conflict;

  // Control word layout {po,ioh,iol,ii,pp,rt,fl,jc,jz,jgt,jlt}
  localparam logic [10:0] C_NONE = 11'h000;
  localparam logic [10:0] C_PO   = 11'h400;
  localparam logic [10:0] C_IOH  = 11'h200;
  localparam logic [10:0] C_IOL  = 11'h100;
  localparam logic [10:0] C_II   = 11'h080;
  localparam logic [10:0] C_PP   = 11'h040;
  localparam logic [10:0] C_RT   = 11'h020;
  localparam logic [10:0] C_FL   = 11'h010;
  localparam logic [10:0] C_JC   = 11'h008;
  localparam logic [10:0] C_JZ   = 11'h004;
  localparam logic [10:0] C_JGT  = 11'h002;
  localparam logic [10:0] C_JLT  = 11'h001;

  int errors = 0;
  int checks = 0;

  // Model state, plain integers
  int m_pc, m_ir, m_t, m_flags, m_ovf;
  bit modelValid = 1'b0;

  cpu_sequencer #(
    .DATA_W    (16),
    .T_BITS    (3),
    .OPC_BITS  (8),
    .IMM_BITS  (8),
    .RESET_VEC (16'h0100)
  ) dut (
    .clk          (clk),
    .RST_bar      (RST_bar),
    .bus_in       (bus_in),
    .bus_out      (bus_out),
    .bus_oe       (bus_oe),
    .uaddr        (uaddr),
    .po           (po),
    .ioh          (ioh),
    .iol          (iol),
    .ii           (ii),
    .pp           (pp),
    .rt           (rt),
    .fl           (fl),
    .jc           (jc),
    .jz           (jz),
    .jgt          (jgt),
    .jlt          (jlt),
    .alu_flags    (alu_flags),
    .stall        (stall),
    .pc           (pc),
    .ir           (ir),
    .t            (t),
    .flags        (flags),
    .t_overflow   (t_overflow),
    .bus_conflict (bus_conflict)
  );

  always #5 clk = ~clk;

  // One comparison; X/Z on the DUT side counts as a mismatch
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive all inputs at once and let combinational outputs settle
  task automatic applyStimulus(input logic rstBar, input logic stallV, input logic [10:0] ctl,
                               input logic [15:0] busV, input logic [2:0] aluV);
    RST_bar   = rstBar;
    stall     = stallV;
    {po, ioh, iol, ii, pp, rt, fl, jc, jz, jgt, jlt} = ctl;
    bus_in    = busV;
    alu_flags = aluV;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: applies the architectural rules at each rising edge
  always @(posedge clk) begin : model
    int c, z, lt;
    bit taken;
    if (!RST_bar) begin
      m_pc = 'h100; m_ir = 0; m_t = 0; m_flags = 0; m_ovf = 0;
    end else if (!stall) begin
      c  = (m_flags >> 2) & 1;
      z  = (m_flags >> 1) & 1;
      lt = m_flags & 1;
      taken = (jc && c != 0) || (jz && z != 0) || (jlt && lt != 0) || (jgt && z == 0 && lt == 0);
      if (taken)   m_pc = int'(bus_in);
      else if (pp) m_pc = (m_pc + 1) % 65536;
      if (ii) m_ir = int'(bus_in);
      if (fl) m_flags = int'(alu_flags);
      if (rt) m_t = 0;
      else begin
        m_t = m_t + 1;
        if (m_t == 8) begin
          m_t = 0;
          m_ovf = 1;
        end
      end
    end
    modelValid = 1'b1;
  end

  // Per-cycle comparison of every output against the model, mid-cycle
  always @(negedge clk) begin : compare
    int expBus, nDrv;
    if (modelValid) begin
      nDrv = int'(po) + int'(ioh) + int'(iol);
      if (po)       expBus = m_pc;
      else if (ioh) expBus = 'hFF00 | (m_ir & 'hFF);
      else if (iol) expBus = m_ir & 'hFF;
      else          expBus = 0;
      checkOutput("cyc_pc",       32'(pc),           32'(m_pc));
      checkOutput("cyc_ir",       32'(ir),           32'(m_ir));
      checkOutput("cyc_t",        32'(t),            32'(m_t));
      checkOutput("cyc_flags",    32'(flags),        32'(m_flags));
      checkOutput("cyc_tovf",     32'(t_overflow),   32'(m_ovf));
      checkOutput("cyc_bus_out",  32'(bus_out),      32'(expBus));
      checkOutput("cyc_bus_oe",   32'(bus_oe),       32'(nDrv > 0));
      checkOutput("cyc_conflict", 32'(bus_conflict), 32'(nDrv >= 2));
      checkOutput("cyc_uaddr",    32'(uaddr),        32'(((m_ir >> 8) * 8) + m_t));
    end
  end

  initial begin
    // Reset held two cycles with stall and load requests active
    applyStimulus(1'b0, 1'b1, C_PP | C_II | C_FL, 16'hDEAD, 3'b111);
    tick();
    tick();
    checkOutput("reset_pc",    32'(pc),         32'h100);
    checkOutput("reset_ir",    32'(ir),         32'h0);
    checkOutput("reset_t",     32'(t),          32'h0);
    checkOutput("reset_flags", 32'(flags),      32'h0);
    checkOutput("reset_tovf",  32'(t_overflow), 32'h0);

    // Fetch: T0 drives PC, T1 loads IR and increments PC
    applyStimulus(1'b1, 1'b0, C_PO, 16'h0000, 3'b000);
    checkOutput("fetch_bus_pc", 32'(bus_out), 32'h100);
    checkOutput("fetch_oe",     32'(bus_oe),  32'h1);
    tick();
    applyStimulus(1'b1, 1'b0, C_II | C_PP, 16'h2A05, 3'b000);
    tick();
    checkOutput("fetch_ir",    32'(ir),    32'h2A05);
    checkOutput("fetch_pc",    32'(pc),    32'h101);
    checkOutput("fetch_t",     32'(t),     32'h2);
    checkOutput("fetch_uaddr", 32'(uaddr), 32'h152);

    // Jumps: each condition taken / not taken, jump beats pp, old flags used
    applyStimulus(1'b1, 1'b0, C_FL | C_RT, 16'h0000, 3'b010);
    tick();
    applyStimulus(1'b1, 1'b0, C_JZ | C_PP | C_RT, 16'h0300, 3'b000);
    tick();
    checkOutput("jz_taken_pc", 32'(pc), 32'h300);
    applyStimulus(1'b1, 1'b0, C_JC | C_PP | C_RT, 16'h0500, 3'b000);
    tick();
    checkOutput("jc_not_taken_pc", 32'(pc), 32'h301);
    applyStimulus(1'b1, 1'b0, C_FL | C_JZ | C_RT, 16'h0777, 3'b000);
    tick();
    checkOutput("jz_old_flags_pc", 32'(pc),    32'h777);
    checkOutput("fl_load_flags",   32'(flags), 32'h0);
    applyStimulus(1'b1, 1'b0, C_JGT | C_RT, 16'h0400, 3'b000);
    tick();
    checkOutput("jgt_taken_pc", 32'(pc), 32'h400);
    applyStimulus(1'b1, 1'b0, C_FL | C_RT, 16'h0000, 3'b001);
    tick();
    applyStimulus(1'b1, 1'b0, C_JGT | C_PP | C_RT, 16'h0999, 3'b000);
    tick();
    checkOutput("jgt_not_taken_pc", 32'(pc), 32'h401);
    applyStimulus(1'b1, 1'b0, C_JLT | C_RT, 16'h0222, 3'b000);
    tick();
    checkOutput("jlt_taken_pc", 32'(pc), 32'h222);
    applyStimulus(1'b1, 1'b0, C_FL | C_RT, 16'h0000, 3'b100);
    tick();
    applyStimulus(1'b1, 1'b0, C_JC | C_RT, 16'h0ABC, 3'b000);
    tick();
    checkOutput("jc_taken_pc", 32'(pc), 32'hABC);

    // Immediates from IR 0x12F3 and bus priority/conflict
    applyStimulus(1'b1, 1'b0, C_II | C_RT, 16'h12F3, 3'b000);
    tick();
    applyStimulus(1'b1, 1'b0, C_IOH | C_RT, 16'h0000, 3'b000);
    checkOutput("ioh_bus", 32'(bus_out), 32'hFFF3);
    tick();
    applyStimulus(1'b1, 1'b0, C_IOL | C_RT, 16'h0000, 3'b000);
    checkOutput("iol_bus", 32'(bus_out), 32'h00F3);
    checkOutput("iol_conflict", 32'(bus_conflict), 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, C_PO | C_IOL | C_RT, 16'h0000, 3'b000);
    checkOutput("po_iol_bus",      32'(bus_out),      32'hABC);
    checkOutput("po_iol_conflict", 32'(bus_conflict), 32'h1);
    tick();
    applyStimulus(1'b1, 1'b0, C_RT, 16'h0000, 3'b000);
    checkOutput("idle_oe",  32'(bus_oe),  32'h0);
    checkOutput("idle_bus", 32'(bus_out), 32'h0);
    tick();

    // Stall at t=1 for three cycles: nothing moves, a pending jump is held off
    applyStimulus(1'b1, 1'b0, C_NONE, 16'h0000, 3'b000);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, C_PP | C_II | C_FL | C_JC | C_IOL, 16'hBEEF, 3'b011);
      checkOutput("stall_bus_follows", 32'(bus_out), 32'h00F3);
      tick();
    end
    checkOutput("stall_pc",    32'(pc),    32'hABC);
    checkOutput("stall_ir",    32'(ir),    32'h12F3);
    checkOutput("stall_t",     32'(t),     32'h1);
    checkOutput("stall_flags", 32'(flags), 32'h4);
    applyStimulus(1'b1, 1'b0, C_PP, 16'h0000, 3'b000);
    tick();
    checkOutput("release_pc", 32'(pc), 32'hABD);
    checkOutput("release_t",  32'(t),  32'h2);

    // T-state overflow: eight steps without rt wrap 7 -> 0 and set the sticky flag
    applyStimulus(1'b1, 1'b0, C_RT, 16'h0000, 3'b000);
    tick();
    checkOutput("ovf_before", 32'(t_overflow), 32'h0);
    applyStimulus(1'b1, 1'b0, C_NONE, 16'h0000, 3'b000);
    for (int i = 0; i < 7; i++) tick();
    checkOutput("ovf_t7",      32'(t),          32'h7);
    checkOutput("ovf_not_yet", 32'(t_overflow), 32'h0);
    tick();
    checkOutput("ovf_wrap_t", 32'(t),          32'h0);
    checkOutput("ovf_set",    32'(t_overflow), 32'h1);
    applyStimulus(1'b1, 1'b0, C_RT, 16'h0000, 3'b000);
    tick();
    checkOutput("ovf_sticky", 32'(t_overflow), 32'h1);

    // PC wrap from all-ones to zero
    applyStimulus(1'b1, 1'b0, C_FL | C_RT, 16'h0000, 3'b000);
    tick();
    applyStimulus(1'b1, 1'b0, C_JGT | C_RT, 16'hFFFF, 3'b000);
    tick();
    checkOutput("pc_ffff", 32'(pc), 32'hFFFF);
    applyStimulus(1'b1, 1'b0, C_PP | C_RT, 16'h0000, 3'b000);
    tick();
    checkOutput("pc_wrap", 32'(pc), 32'h0);

    // Reset again under stall clears the sticky overflow
    applyStimulus(1'b0, 1'b1, C_PP, 16'h0000, 3'b000);
    tick();
    checkOutput("rereset_pc",   32'(pc),         32'h100);
    checkOutput("rereset_tovf", 32'(t_overflow), 32'h0);
    checkOutput("rereset_t",    32'(t),          32'h0);
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
